// File: rtl/idli_pkg.sv
// Shared types and constants for the idli UART blocks.
package idli_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/idli_uart_rx_fifo_m.sv
// Small byte FIFO with a push/full write side and a valid/ready read side.
module idli_uart_rx_fifo_m
    import idli_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  uart_byte_t i_data,
    output logic       o_full,
    output uart_byte_t o_data,
    output logic       o_valid,
    input  logic       i_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    uart_byte_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_cnt;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_pop  = o_valid & i_ready;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/idli_uart_rx_m.sv
// 8N1 UART receiver: synchroniser, bit-timing FSM and a byte FIFO with
// sticky frame-error / overflow flags.
module idli_uart_rx_m
    import idli_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       i_urx_gck,
    input  logic       i_urx_rst_n,
    input  logic       i_urx_rx,
    output logic [7:0] o_urx_data,
    output logic       o_urx_valid,
    input  logic       i_urx_ready,
    output logic       o_urx_frame_err,
    output logic       o_urx_overflow,
    input  logic       i_urx_clr
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CYCLES_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CYCLES_PER_BIT - 1);

    logic           r_sync1;
    logic           r_sync2;
    uart_rx_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]     r_idx;
    uart_byte_t     r_shift;
    logic           r_push;
    uart_byte_t     r_byte;
    logic           r_frame_err;
    logic           r_overflow;

    uart_rx_state_t w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]     w_idx_nxt;
    uart_byte_t     w_shift_nxt;
    logic           w_push_nxt;
    logic           w_fe_set;
    logic           w_ovf_set;
    logic           w_rx_sync;
    logic           w_expire;
    logic           w_full;
    logic           w_pop;

    assign w_rx_sync = r_sync2;
    assign w_expire  = (r_cnt == '0);

    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_urx_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        w_fe_set    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = r_cnt;
                if (!w_rx_sync) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = HALF_RELOAD;
                end
            end
            START: begin
                if (w_expire) begin
                    if (w_rx_sync) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = BIT_RELOAD;
                        w_idx_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {w_rx_sync, r_shift[UART_DATA_BITS-1:1]};
                    w_cnt_nxt   = BIT_RELOAD;
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_expire) begin
                    if (w_rx_sync) begin
                        w_push_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_fe_set    = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line: stay here so a break yields one error only.
                w_cnt_nxt = r_cnt;
                if (w_rx_sync) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_push  <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_push  <= w_push_nxt;
            if (w_push_nxt) begin
                r_byte <= r_shift;
            end
        end
    end

    assign w_pop     = o_urx_valid & i_urx_ready;
    assign w_ovf_set = r_push & w_full & ~w_pop;

    // Set wins over a coincident clear so no event is ever lost.
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_fe_set  | (r_frame_err & ~i_urx_clr);
            r_overflow  <= w_ovf_set | (r_overflow  & ~i_urx_clr);
        end
    end

    assign o_urx_frame_err = r_frame_err;
    assign o_urx_overflow  = r_overflow;

    idli_uart_rx_fifo_m #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_urx_gck),
        .i_rst_n (i_urx_rst_n),
        .i_push  (r_push),
        .i_data  (r_byte),
        .o_full  (w_full),
        .o_data  (o_urx_data),
        .o_valid (o_urx_valid),
        .i_ready (i_urx_ready)
    );

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Scenario bench for idli_uart_rx_m: bytes expected are queued as frames are
// sent and compared when the receiver hands them out.
module tb_idli_uart_rx_m;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err;
    logic       overflow;
    logic       clr = 1'b0;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;
    int         fe_rises = 0;
    logic       fe_d = 1'b0;

    always #5 clk = ~clk;

    idli_uart_rx_m #(
        .CYCLES_PER_BIT (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_urx_gck       (clk),
        .i_urx_rst_n     (rst_n),
        .i_urx_rx        (rx),
        .o_urx_data      (data),
        .o_urx_valid     (valid),
        .i_urx_ready     (ready),
        .o_urx_frame_err (frame_err),
        .o_urx_overflow  (overflow),
        .i_urx_clr       (clr)
    );

    // Scoreboard: every accepted byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got byte %h, required no byte", data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_data: got %h, required %h", data, sb_exp);
                end
            end
        end
        if (frame_err && !fe_d) fe_rises++;
        fe_d = frame_err;
    end

    // Start bit is first seen at the posedge after rx falls (edge 0);
    // returns at edge 10*CPB-1, the last edge of the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b, required 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        @(posedge clk); #1;   // edge 40
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_early: got valid %b, required 0", valid); end
        @(posedge clk); #1;   // edge 41
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got valid %b, required 1", valid); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL lat_data: got %h, required a5", data); end
        @(posedge clk); #1;   // edge 42
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: got valid %b, required 0", valid); end
        checks++; if ({frame_err, overflow} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b, required 00", {frame_err, overflow}); end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles, required 0", seen); end
        checks++; if ({frame_err, overflow} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b, required 00", {frame_err, overflow}); end
        // A real frame right after proves the FSM went back to idle.
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        repeat (4) @(posedge clk); #1;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL glitch_recover: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_frame_err();
        fe_rises = 0;
        send_frame(8'h3C, 1'b0);
        repeat (20) @(posedge clk); #1;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_set: got %b, required 1", frame_err); end
        checks++; if (fe_rises !== 1) begin errors++; $display("FAIL fe_once: got %0d rises, required 1", fe_rises); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fe_no_byte: got valid %b, required 0", valid); end
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_clr: got %b, required 0", frame_err); end
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (4) @(posedge clk); #1;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL fe_next_byte: got %0d pending, required 0", exp_q.size()); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_stays_clear: got %b, required 0", frame_err); end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= DEPTH) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        repeat (3) @(posedge clk); #1;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        checks++; if (data !== 8'h01) begin errors++; $display("FAIL ovf_head: got %h, required 01", data); end
        ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got valid %b, required 0", valid); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_pending: got %0d, required 0", exp_q.size()); end
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b, required 0", overflow); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        @(posedge clk); #1 ready = 1'b1;   // high for the push edge only
        @(posedge clk); #1 ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf: got %b, required 0", overflow); end
        checks++; if (data !== 8'h02) begin errors++; $display("FAIL b2b_head: got %h, required 02", data); end
        ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL clr_pre: got %b, required 0", frame_err); end
        send_frame(8'h5A, 1'b0);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;      // error set on this edge
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b, required 1", frame_err); end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic test_reset_midframe();
        ready = 1'b0;
        send_frame(8'h7E, 1'b1);
        repeat (3) @(posedge clk); #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b, required 1", valid); end
        @(posedge clk); #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h, required 00", data); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        repeat (4) @(posedge clk); #1;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_next: got %0d pending, required 0", exp_q.size()); end
        checks++; if ({frame_err, overflow} !== 2'b00) begin errors++; $display("FAIL mid_flags: got %b, required 00", {frame_err, overflow}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
